// File: rtl/uart_pkg.sv
// Shared UART definitions: default clocking, FSM state encodings, parity modes
// and a parity helper used by the transmitter and its companion receiver.
package uart_pkg;

  localparam int DEFAULT_CLK_FREQ  = 50000000;
  localparam int DEFAULT_BAUD_RATE = 115200;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Even mode returns the XOR of the data; odd mode returns its complement.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    logic p;
    p = ^data;
    case (mode)
      PARITY_ODD: parity_bit = ~p;
      default:    parity_bit = p;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-stream valid/ready handshake feeding the UART transmitter.
interface uart_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO; dout presents the head entry while not empty.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [7:0]       mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             push_s;
  logic             pop_s;

  assign full   = (count_r == CNT_FULL);
  assign empty  = (count_r == '0);
  assign count  = count_r;
  assign dout   = mem_r[rd_ptr_r];
  assign push_s = push & ~full;
  assign pop_s  = pop & ~empty;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffered bytes are framed as start, 8 data bits LSB first,
// optional parity and stop, sent back-to-back while the FIFO holds data.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = DEFAULT_CLK_FREQ,
  parameter int BAUD_RATE    = DEFAULT_BAUD_RATE,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY       = PARITY_NONE
) (
  input  logic                          clk,
  input  logic                          rst_n,
  uart_tx_if.slave                      bus,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [2:0]       state_r;
  logic [CNT_W-1:0] bit_cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             par_r;
  logic             tx_r;

  logic [7:0]       fifo_dout_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             fifo_pop_s;
  logic             bit_last_s;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.tx_valid),
    .pop   (fifo_pop_s),
    .din   (bus.tx_data),
    .dout  (fifo_dout_s),
    .count (fifo_count),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign bus.tx_ready = ~fifo_full_s;
  assign tx           = tx_r;
  assign tx_busy      = (state_r != ST_IDLE);
  assign bit_last_s   = (bit_cnt_r == CNT_LAST);

  // Head byte is taken when idle or on the last stop cycle, so frames abut.
  always_comb begin
    fifo_pop_s = 1'b0;
    if (!fifo_empty_s && ((state_r == ST_IDLE) || ((state_r == ST_STOP) && bit_last_s))) begin
      fifo_pop_s = 1'b1;
    end else begin
      fifo_pop_s = 1'b0;
    end
  end

  // Framing FSM; tx is updated one cycle ahead so each bit lasts exactly CLKS_PER_BIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      par_r     <= 1'b0;
      tx_r      <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tx_r <= 1'b1;
          if (fifo_pop_s) begin
            shift_r   <= fifo_dout_s;
            par_r     <= parity_bit(fifo_dout_s, PARITY);
            bit_cnt_r <= '0;
            bit_idx_r <= 3'd0;
            tx_r      <= 1'b0;
            state_r   <= ST_START;
          end
        end
        ST_START: begin
          if (bit_last_s) begin
            bit_cnt_r <= '0;
            tx_r      <= shift_r[0];
            state_r   <= ST_DATA;
          end else begin
            bit_cnt_r <= bit_cnt_r + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (bit_last_s) begin
            bit_cnt_r <= '0;
            if (bit_idx_r == 3'd7) begin
              if (PARITY != PARITY_NONE) begin
                tx_r    <= par_r;
                state_r <= ST_PARITY;
              end else begin
                tx_r    <= 1'b1;
                state_r <= ST_STOP;
              end
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx_r      <= shift_r[1];
              shift_r   <= {1'b0, shift_r[7:1]};
            end
          end else begin
            bit_cnt_r <= bit_cnt_r + CNT_ONE;
          end
        end
        ST_PARITY: begin
          if (bit_last_s) begin
            bit_cnt_r <= '0;
            tx_r      <= 1'b1;
            state_r   <= ST_STOP;
          end else begin
            bit_cnt_r <= bit_cnt_r + CNT_ONE;
          end
        end
        ST_STOP: begin
          if (bit_last_s) begin
            bit_cnt_r <= '0;
            if (fifo_pop_s) begin
              shift_r   <= fifo_dout_s;
              par_r     <= parity_bit(fifo_dout_s, PARITY);
              bit_idx_r <= 3'd0;
              tx_r      <= 1'b0;
              state_r   <= ST_START;
            end else begin
              tx_r    <= 1'b1;
              state_r <= ST_IDLE;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          bit_cnt_r <= '0;
          tx_r      <= 1'b1;
        end
      endcase
    end
  end

endmodule
